// File: rtl/captura_entrada.sv
// captura_entrada: button/switch input conditioning for the lock FSM.
// Synchronises, debounces and BCD-checks one digit per button press.
module captura_entrada #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       insere_btn,
    input  logic [3:0] entrada_sw,
    output logic       insere,
    output logic [3:0] entrada,
    output logic       erro_digito,
    output logic       ocupado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMANDO,
        PRESSIONADO,
        SOLTANDO
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;

    logic            btn_m;
    logic            btn_s;
    logic [3:0]      sw_m;
    logic [3:0]      sw_s;

    logic            captura;
    logic            digito_ok;

    // Two-flop synchronisers for the asynchronous button and switches
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= 4'd0;
            sw_s  <= 4'd0;
        end else begin
            btn_m <= insere_btn;
            btn_s <= btn_m;
            sw_m  <= entrada_sw;
            sw_s  <= sw_m;
        end
    end

    // State and debounce counter registers; reset parks in SOLTANDO so a
    // button held through reset must be released before it can count
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SOLTANDO;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and counter logic; the counter restarts on any state change
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        captura    = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = ARMANDO;
                end
            end
            ARMANDO: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSIONADO;
                    captura    = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSIONADO: begin
                if (!btn_s) begin
                    state_next = SOLTANDO;
                end
            end
            SOLTANDO: begin
                if (btn_s) begin
                    state_next = PRESSIONADO;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = SOLTANDO;
            end
        endcase
        if (state_next != state) begin
            cnt_next = '0;
        end
    end

    assign digito_ok = (sw_s <= 4'd9);

    // Registered strobes and digit capture at the accepting edge
    always_ff @(posedge clk) begin
        if (reset) begin
            insere      <= 1'b0;
            erro_digito <= 1'b0;
            entrada     <= 4'd0;
        end else begin
            insere      <= captura && digito_ok;
            erro_digito <= captura && !digito_ok;
            if (captura && digito_ok) begin
                entrada <= sw_s;
            end
        end
    end

    assign ocupado = (state != IDLE);

endmodule
